ysyx_25060170_lsu: RTL and testbench

YSYX_25060170_LSU -- requirements
Module: ysyx_25060170_LSU

---
 rtl/ysyx_25060170_lsu.sv | 215 +++++++++++++++++++++
 tb/tb_ysyx_25060170_lsu.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25060170_lsu.sv
// ---------------------------------------------------------------------------
// ysyx_25060170_lsu -- load/store unit between the EXU and the WBU.
//
// Accepts one instruction at a time from the EXU, issues at most one
// word-aligned data-memory request for loads/stores, aligns and extends
// load data, and hands a write-back record to the WBU.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   in_valid/in_ready   EXU handshake (in_ready high only when idle)
//   in_addr             ALU result: memory address, or write-back value
//   in_wdata            store data (rs2)
//   in_ren, in_wen      load / store request (both high = store)
//   in_size             funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
//   in_rd, in_rd_wen    destination register and write enable
//   mem_req_*           word-aligned request: addr, wen, byte mask, wdata
//   mem_resp_*          completion strobe and word read data
//   out_valid/out_ready WBU handshake
//   out_wdata, out_rd, out_rd_wen, out_err   write-back record
//
// Build option
//   YSYX_25060170_LSU_MISALIGN_CHECK_EN  when defined, misaligned h/w
//   accesses skip memory and retire with out_err=1. When undefined,
//   out_err is tied to 0 and misaligned masks are simply truncated.
// ---------------------------------------------------------------------------
module ysyx_25060170_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic        in_ren,
  input  logic        in_wen,
  input  logic [2:0]  in_size,
  input  logic [4:0]  in_rd,
  input  logic        in_rd_wen,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [3:0]  mem_req_wmask,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_wdata,
  output logic [4:0]  out_rd,
  output logic        out_rd_wen,
  output logic        out_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_OUT} state_e;
  typedef enum logic [1:0] {W_B, W_H, W_W} width_e;

  // Unlisted funct3 codes fall into the word class.
  function automatic width_e decode_width(input logic [2:0] size);
    case (size)
      3'b000, 3'b100: return W_B;
      3'b001, 3'b101: return W_H;
      default:        return W_W;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wen_q, wen_d;
  logic [2:0]  size_q, size_d;
  logic [4:0]  rd_q, rd_d;
  logic        rd_wen_q, rd_wen_d;
  logic [31:0] out_wdata_q, out_wdata_d;

  logic        in_misalign;
  logic [1:0]  off;
  logic [31:0] rdata_sh;
  logic [31:0] load_data;

`ifdef YSYX_25060170_LSU_MISALIGN_CHECK_EN
  logic err_q, err_d;
  width_e in_width;
  assign in_width    = decode_width(in_size);
  assign in_misalign = (in_ren | in_wen) &&
                       ((in_width == W_H && in_addr[0]) ||
                        (in_width == W_W && in_addr[1:0] != 2'b00));
  assign out_err     = err_q;
`else
  assign in_misalign = 1'b0;
  assign out_err     = 1'b0;
`endif

  assign off = addr_q[1:0];

  // Load alignment: bring the addressed byte/half down to bit 0, then extend.
  assign rdata_sh = mem_resp_rdata >> {off, 3'b000};

  always_comb begin
    load_data = rdata_sh;
    case (size_q)
      3'b000:  load_data = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      3'b100:  load_data = {24'h0, rdata_sh[7:0]};
      3'b001:  load_data = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
      3'b101:  load_data = {16'h0, rdata_sh[15:0]};
      default: load_data = rdata_sh;
    endcase
  end

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wen_d       = wen_q;
    size_d      = size_q;
    rd_d        = rd_q;
    rd_wen_d    = rd_wen_q;
    out_wdata_d = out_wdata_q;
`ifdef YSYX_25060170_LSU_MISALIGN_CHECK_EN
    err_d       = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          addr_d   = in_addr;
          wdata_d  = in_wdata;
          wen_d    = in_wen;
          size_d   = in_size;
          rd_d     = in_rd;
          // Stores and faulting accesses never write back; x0 is never written.
          rd_wen_d = in_rd_wen && (in_rd != 5'd0) && !in_wen && !in_misalign;
`ifdef YSYX_25060170_LSU_MISALIGN_CHECK_EN
          err_d    = in_misalign;
`endif
          if ((in_ren || in_wen) && !in_misalign) begin
            state_d = S_REQ;
          end else begin
            out_wdata_d = in_addr;
            state_d     = S_OUT;
          end
        end
      end
      S_REQ: begin
        // A response strobe here belongs to nobody and is ignored.
        if (mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          out_wdata_d = wen_q ? 32'h0 : load_data;
          state_d     = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      wen_q       <= 1'b0;
      size_q      <= 3'b0;
      rd_q        <= 5'd0;
      rd_wen_q    <= 1'b0;
      out_wdata_q <= 32'h0;
`ifdef YSYX_25060170_LSU_MISALIGN_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wen_q       <= wen_d;
      size_q      <= size_d;
      rd_q        <= rd_d;
      rd_wen_q    <= rd_wen_d;
      out_wdata_q <= out_wdata_d;
`ifdef YSYX_25060170_LSU_MISALIGN_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  // Request fields come straight from the latched operands, so they stay
  // stable for as long as the request is held.
  always_comb begin
    mem_req_wmask = 4'b0000;
    if (wen_q) begin
      case (decode_width(size_q))
        W_B:     mem_req_wmask = 4'b0001 << off;
        W_H:     mem_req_wmask = 4'b0011 << off;
        default: mem_req_wmask = 4'b1111;
      endcase
    end
  end

  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_addr  = {addr_q[31:2], 2'b00};
  assign mem_req_wen   = wen_q;
  assign mem_req_wdata = wdata_q << {off, 3'b000};

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_OUT);
  assign out_wdata  = out_wdata_q;
  assign out_rd     = rd_q;
  assign out_rd_wen = rd_wen_q;

endmodule

// File: tb/tb_ysyx_25060170_lsu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_25060170_lsu -- self-checking bench for ysyx_25060170_lsu.
// Expected write-back records are queued when an instruction is accepted
// and compared when the WBU handshake completes. Request fields and
// handshake timing are checked inline by the driver.
// ---------------------------------------------------------------------------
module tb_ysyx_25060170_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr, in_wdata;
  logic        in_ren, in_wen;
  logic [2:0]  in_size;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [3:0]  mem_req_wmask;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        out_valid, out_ready;
  logic [31:0] out_wdata;
  logic [4:0]  out_rd;
  logic        out_rd_wen, out_err;

  ysyx_25060170_lsu dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_wdata(in_wdata),
    .in_ren(in_ren), .in_wen(in_wen), .in_size(in_size),
    .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wmask(mem_req_wmask), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wdata(out_wdata), .out_rd(out_rd),
    .out_rd_wen(out_rd_wen), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ren;
    logic        wen;
    logic [2:0]  size;
    logic [4:0]  rd;
    logic        rd_wen;
    logic [31:0] rdata;
    int          req_dly;
    int          out_dly;
  } op_t;

  typedef struct {
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        err;
    logic        mem;
    logic [3:0]  wmask;
    logic [31:0] mwdata;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour, written byte-lane by byte-lane.
  function automatic exp_t model(input op_t o);
    exp_t        e;
    int          nb;
    int          off;
    logic [31:0] sh;
    logic        mem;
    logic        mis;
    off = int'(o.addr[1:0]);
    case (o.size)
      3'b000, 3'b100: nb = 1;
      3'b001, 3'b101: nb = 2;
      default:        nb = 4;
    endcase
    mem = o.ren | o.wen;
`ifdef YSYX_25060170_LSU_MISALIGN_CHECK_EN
    mis = mem && ((nb == 2 && off % 2 == 1) || (nb == 4 && off != 0));
`else
    mis = 1'b0;
`endif
    e.err    = mis;
    e.mem    = mem && !mis;
    e.rd     = o.rd;
    e.rd_wen = o.rd_wen && (o.rd != 5'd0) && !o.wen && !mis;
    e.wmask  = 4'b0000;
    if (o.wen && !mis)
      for (int b = 0; b < 4; b++) e.wmask[b] = (nb == 4) || (b >= off && b < off + nb);
    e.mwdata = o.wdata << (8 * off);
    sh = o.rdata >> (8 * off);
    if (mis || !mem)   e.wdata = o.addr;
    else if (o.wen)    e.wdata = 32'h0;
    else begin
      case (o.size)
        3'b000:  e.wdata = {{24{sh[7]}}, sh[7:0]};
        3'b100:  e.wdata = {24'h0, sh[7:0]};
        3'b001:  e.wdata = {{16{sh[15]}}, sh[15:0]};
        3'b101:  e.wdata = {16'h0, sh[15:0]};
        default: e.wdata = sh;
      endcase
    end
    return e;
  endfunction

  // Compare every WBU handshake against the oldest queued record.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 32'(out_valid), 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_wdata", out_wdata, e.wdata);
        check("out_rd", 32'(out_rd), 32'(e.rd));
        check("out_rd_wen", 32'(out_rd_wen), 32'(e.rd_wen));
        check("out_err", 32'(out_err), 32'(e.err));
      end
    end
  end

  task automatic check_req(input op_t o, input exp_t e);
    check("req_valid", 32'(mem_req_valid), 32'h1);
    check("req_addr", mem_req_addr, {o.addr[31:2], 2'b00});
    check("req_wen", 32'(mem_req_wen), 32'(o.wen));
    check("req_wmask", 32'(mem_req_wmask), 32'(e.wmask));
    if (o.wen) check("req_wdata", mem_req_wdata, e.mwdata);
  endtask

  // Runs one instruction end to end; entered and left just after a rising edge.
  task automatic do_op(input op_t o, input exp_t e);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("in_ready_idle", 32'(in_ready), 32'h1);
    in_valid  = 1'b1;
    in_addr   = o.addr;
    in_wdata  = o.wdata;
    in_ren    = o.ren;
    in_wen    = o.wen;
    in_size   = o.size;
    in_rd     = o.rd;
    in_rd_wen = o.rd_wen;
    sb.push_back(e);
    tick();
    // Garbage on the inputs proves the fields were latched.
    in_valid  = 1'b0;
    in_addr   = $urandom;
    in_wdata  = $urandom;
    in_ren    = 1'($urandom);
    in_wen    = 1'($urandom);
    in_size   = 3'($urandom);
    in_rd     = 5'($urandom);
    in_rd_wen = 1'($urandom);
    if (e.mem) begin
      for (int i = 0; i < o.req_dly; i++) begin
        @(negedge clk);
        check_req(o, e);
        check("in_ready_req", 32'(in_ready), 32'h0);
        if (i == 0) begin
          mem_resp_valid = 1'b1;   // stray response must be ignored in REQ
          mem_resp_rdata = ~o.rdata;
        end
        tick();
        mem_resp_valid = 1'b0;
      end
      @(negedge clk);
      check_req(o, e);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      @(negedge clk);
      check("req_valid_wait", 32'(mem_req_valid), 32'h0);
      check("in_ready_wait", 32'(in_ready), 32'h0);
      mem_resp_valid = 1'b1;
      mem_resp_rdata = o.rdata;
      tick();
      mem_resp_valid = 1'b0;
      mem_resp_rdata = $urandom;
    end
    for (int i = 0; i <= o.out_dly; i++) begin
      if (i == o.out_dly) out_ready = 1'b1;
      @(negedge clk);
      check("out_valid_hold", 32'(out_valid), 32'h1);
      check("in_ready_out", 32'(in_ready), 32'h0);
      check("req_valid_out", 32'(mem_req_valid), 32'h0);
      check("out_wdata_hold", out_wdata, e.wdata);
      tick();
    end
    out_ready = 1'b0;
    @(negedge clk);
    check("out_valid_done", 32'(out_valid), 32'h0);
    check("in_ready_done", 32'(in_ready), 32'h1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    op_t         o;
    exp_t        e;
    logic [2:0]  sizes [6];
    sizes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};

    rst = 1'b1;
    in_valid = 1'b0; in_addr = '0; in_wdata = '0; in_ren = 1'b0; in_wen = 1'b0;
    in_size = '0; in_rd = '0; in_rd_wen = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_req_valid", 32'(mem_req_valid), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_rd_wen", 32'(out_rd_wen), 32'h0);
    check("rst_out_err", 32'(out_err), 32'h0);
    check("rst_out_wdata", out_wdata, 32'h0);
    check("rst_out_rd", 32'(out_rd), 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // ALU op: one-cycle pass-through of in_addr.
    o = '{addr:32'h1234, wdata:32'h0, ren:1'b0, wen:1'b0, size:3'b000, rd:5'd5,
          rd_wen:1'b1, rdata:32'h0, req_dly:0, out_dly:0};
    do_op(o, '{wdata:32'h1234, rd:5'd5, rd_wen:1'b1, err:1'b0, mem:1'b0, wmask:4'h0, mwdata:32'h0});

    // lb from the top byte, request ready delayed 3 cycles.
    o = '{addr:32'h80000003, wdata:32'h0, ren:1'b1, wen:1'b0, size:3'b000, rd:5'd7,
          rd_wen:1'b1, rdata:32'h80FFFFFF, req_dly:3, out_dly:0};
    do_op(o, '{wdata:32'hFFFFFF80, rd:5'd7, rd_wen:1'b1, err:1'b0, mem:1'b1, wmask:4'h0, mwdata:32'h0});

    // sh to the upper half.
    o = '{addr:32'h2, wdata:32'h0000ABCD, ren:1'b0, wen:1'b1, size:3'b001, rd:5'd9,
          rd_wen:1'b1, rdata:32'h0, req_dly:1, out_dly:0};
    do_op(o, '{wdata:32'h0, rd:5'd9, rd_wen:1'b0, err:1'b0, mem:1'b1, wmask:4'b1100, mwdata:32'hABCD0000});

    // lhu with WBU back-pressure for 4 cycles.
    o = '{addr:32'h0, wdata:32'h0, ren:1'b1, wen:1'b0, size:3'b101, rd:5'd10,
          rd_wen:1'b1, rdata:32'h00018001, req_dly:0, out_dly:4};
    do_op(o, '{wdata:32'h8001, rd:5'd10, rd_wen:1'b1, err:1'b0, mem:1'b1, wmask:4'h0, mwdata:32'h0});

    // rd = x0 suppresses write-back.
    o = '{addr:32'hCAFE0000, wdata:32'h0, ren:1'b0, wen:1'b0, size:3'b010, rd:5'd0,
          rd_wen:1'b1, rdata:32'h0, req_dly:0, out_dly:1};
    do_op(o, '{wdata:32'hCAFE0000, rd:5'd0, rd_wen:1'b0, err:1'b0, mem:1'b0, wmask:4'h0, mwdata:32'h0});

    // ren and wen both high: a word store.
    o = '{addr:32'h10, wdata:32'h11223344, ren:1'b1, wen:1'b1, size:3'b010, rd:5'd3,
          rd_wen:1'b1, rdata:32'h0, req_dly:0, out_dly:0};
    do_op(o, '{wdata:32'h0, rd:5'd3, rd_wen:1'b0, err:1'b0, mem:1'b1, wmask:4'b1111, mwdata:32'h11223344});

    // Unlisted size on a load behaves as lw.
    o = '{addr:32'h20, wdata:32'h0, ren:1'b1, wen:1'b0, size:3'b011, rd:5'd4,
          rd_wen:1'b1, rdata:32'hDEADBEEF, req_dly:0, out_dly:0};
    do_op(o, '{wdata:32'hDEADBEEF, rd:5'd4, rd_wen:1'b1, err:1'b0, mem:1'b1, wmask:4'h0, mwdata:32'h0});

    // lbu and lh sign/zero extension.
    o = '{addr:32'h1, wdata:32'h0, ren:1'b1, wen:1'b0, size:3'b100, rd:5'd6,
          rd_wen:1'b1, rdata:32'h0000F200, req_dly:0, out_dly:0};
    do_op(o, '{wdata:32'h000000F2, rd:5'd6, rd_wen:1'b1, err:1'b0, mem:1'b1, wmask:4'h0, mwdata:32'h0});
    o = '{addr:32'h2, wdata:32'h0, ren:1'b1, wen:1'b0, size:3'b001, rd:5'd8,
          rd_wen:1'b1, rdata:32'h9ABC0000, req_dly:0, out_dly:0};
    do_op(o, '{wdata:32'hFFFF9ABC, rd:5'd8, rd_wen:1'b1, err:1'b0, mem:1'b1, wmask:4'h0, mwdata:32'h0});

`ifdef YSYX_25060170_LSU_MISALIGN_CHECK_EN
    // Misaligned lw faults without touching memory.
    o = '{addr:32'h6, wdata:32'h0, ren:1'b1, wen:1'b0, size:3'b010, rd:5'd11,
          rd_wen:1'b1, rdata:32'h0, req_dly:0, out_dly:0};
    do_op(o, '{wdata:32'h6, rd:5'd11, rd_wen:1'b0, err:1'b1, mem:1'b0, wmask:4'h0, mwdata:32'h0});
    // Misaligned sh faults as well.
    o = '{addr:32'h3, wdata:32'h00001234, ren:1'b0, wen:1'b1, size:3'b001, rd:5'd12,
          rd_wen:1'b0, rdata:32'h0, req_dly:0, out_dly:0};
    do_op(o, '{wdata:32'h3, rd:5'd12, rd_wen:1'b0, err:1'b1, mem:1'b0, wmask:4'h0, mwdata:32'h0});
`else
    // Misaligned sh: mask truncated to the top lane.
    o = '{addr:32'h3, wdata:32'h00001234, ren:1'b0, wen:1'b1, size:3'b001, rd:5'd12,
          rd_wen:1'b0, rdata:32'h0, req_dly:0, out_dly:0};
    do_op(o, '{wdata:32'h0, rd:5'd12, rd_wen:1'b0, err:1'b0, mem:1'b1, wmask:4'b1000, mwdata:32'h34000000});
`endif

    // Randomised mix checked against the model.
    for (int k = 0; k < 24; k++) begin
      int kind;
      kind     = int'($urandom_range(0, 3));
      o.addr   = $urandom;
      o.wdata  = $urandom;
      o.rdata  = $urandom;
      o.ren    = (kind == 1 || kind == 3);
      o.wen    = (kind == 2 || kind == 3);
      o.size   = sizes[$urandom_range(0, 5)];
      if (o.size == 3'b010 || o.size == 3'b011) o.addr[1:0] = 2'b00;
      o.rd      = 5'($urandom);
      o.rd_wen  = 1'($urandom);
      o.req_dly = int'($urandom_range(0, 2));
      o.out_dly = int'($urandom_range(0, 2));
      e = model(o);
      do_op(o, e);
    end

    // Reset while waiting for a response abandons the access.
    in_valid = 1'b1; in_addr = 32'h100; in_ren = 1'b1; in_wen = 1'b0;
    in_size = 3'b010; in_rd = 5'd3; in_rd_wen = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("abort_req_valid", 32'(mem_req_valid), 32'h1);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    @(negedge clk);
    check("abort_in_wait", 32'(mem_req_valid), 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h55AA55AA;
    tick();
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_out_valid", 32'(out_valid), 32'h0);
      check("abort_in_ready", 32'(in_ready), 32'h1);
      check("abort_req_idle", 32'(mem_req_valid), 32'h0);
      tick();
    end

    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
